// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised up/down counter.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_e;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// Optional capture port pair present only when COUNTER_CAPTURE_EN is defined.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  en;
  logic                  dir;
  logic [1:0]            mode;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  done;
  logic                  running;
`ifdef COUNTER_CAPTURE_EN
  logic                  capture;
  logic [WIDTH-1:0]      cap_val;

  modport master (
    output en, dir, mode, load, load_val, prescale, capture,
    input  count, tc, done, running, cap_val
  );
  modport slave (
    input  en, dir, mode, load, load_val, prescale, capture,
    output count, tc, done, running, cap_val
  );
`else
  modport master (
    output en, dir, mode, load, load_val, prescale,
    input  count, tc, done, running
  );
  modport slave (
    input  en, dir, mode, load, load_val, prescale,
    output count, tc, done, running
  );
`endif
endinterface

// File: rtl/counter_prescaler.sv
// Clock-enable divider: tick_o fires once every prescale_i+1 running cycles.
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= so a prescale lowered below the current count still ends the period at once
  assign tick_o = run_i && (cnt_q >= prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with terminal value, load, prescaler and wrap/sat/oneshot/hold modes.
// Define COUNTER_CAPTURE_EN to add the capture/cap_val snapshot register.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  MAX_VAL    = '1,
  parameter int unsigned       PRESCALE_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  param_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  state_e           state_q, state_d;

  logic             tick;
  logic             run;
  mode_e            mode;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic             at_term;

  assign mode         = mode_e'(bus.mode);
  assign run          = bus.en && (state_q == ST_RUN);
  assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
  assign term_val     = bus.dir ? MAX_VAL : '0;
  assign at_term      = (count_q == term_val);

  always_comb begin
    if (bus.dir) begin
      step_val = (count_q == MAX_VAL) ? '0 : count_q + 1'b1;
    end else begin
      step_val = (count_q == '0) ? MAX_VAL : count_q - 1'b1;
    end
  end

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (bus.load),
    .run_i      (run),
    .prescale_i (bus.prescale),
    .tick_o     (tick)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (bus.load) begin
      count_d = load_clamped;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (tick) begin
      unique case (mode)
        MODE_WRAP:    count_d = step_val;
        MODE_SAT:     count_d = at_term ? count_q : step_val;
        MODE_ONESHOT: count_d = at_term ? count_q : step_val;
        MODE_HOLD:    count_d = count_q;
        default:      count_d = count_q;
      endcase
      // tc only on arrival at the terminal, never while already parked there
      if (mode != MODE_HOLD) begin
        tc_d = (count_d == term_val) && !at_term;
      end
      if ((mode == MODE_ONESHOT) && (count_d == term_val)) begin
        state_d = ST_STOP;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.done    = done_q;
  assign bus.running = (state_q == ST_RUN);

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
    end else if (bus.capture) begin
      cap_q <= count_q;
    end
  end

  assign bus.cap_val = cap_q;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter (WIDTH=8, MAX_VAL=9).
module tb_param_updown_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  param_updown_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

  param_updown_counter #(
    .WIDTH      (8),
    .MAX_VAL    (8'd9),
    .PRESCALE_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ct(input string tag, input int exp_count, input bit exp_tc);
    chk({tag, " count"}, 32'(bus.count), 32'(exp_count));
    chk({tag, " tc"}, 32'(bus.tc), 32'(exp_tc));
  endtask

  initial begin
    int exp_c[];
    bit exp_t[];
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.dir      = 1'b1;
    bus.mode     = 2'b00;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.prescale = '0;
`ifdef COUNTER_CAPTURE_EN
    bus.capture  = 1'b0;
`endif
    step();
    step();
    chk_ct("reset", 0, 1'b0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset running", 32'(bus.running), 32'd1);
    rst = 1'b0;

    // WRAP up, prescale 0: 1..9 then 0, tc on reaching 9
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_ct("wrap_up", i % 10, (i == 9));
    end

    // SAT down from load 3
    bus.mode     = 2'b01;
    bus.dir      = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 8'd3;
    step();
    chk_ct("sat_load", 3, 1'b0);
    bus.load = 1'b0;
    exp_c = '{2, 1, 0, 0, 0};
    exp_t = '{0, 0, 1, 0, 0};
    foreach (exp_c[i]) begin
      step();
      chk_ct("sat_down", exp_c[i], exp_t[i]);
    end

    // ONESHOT up from 6: 7,8,9 then STOP
    bus.mode     = 2'b10;
    bus.dir      = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'd6;
    step();
    chk_ct("os_load", 6, 1'b0);
    bus.load = 1'b0;
    exp_c = '{7, 8, 9, 9, 9};
    exp_t = '{0, 0, 1, 0, 0};
    foreach (exp_c[i]) begin
      step();
      chk_ct("oneshot", exp_c[i], exp_t[i]);
    end
    chk("os done", 32'(bus.done), 32'd1);
    chk("os running", 32'(bus.running), 32'd0);
    bus.mode = 2'b00;
    step();
    chk_ct("stop_mode_chg", 9, 1'b0);
    chk("stop_mode_chg running", 32'(bus.running), 32'd0);
    bus.mode     = 2'b10;
    bus.load     = 1'b1;
    bus.load_val = 8'd1;
    step();
    chk_ct("os_reload", 1, 1'b0);
    chk("os_reload done", 32'(bus.done), 32'd0);
    chk("os_reload running", 32'(bus.running), 32'd1);
    bus.load = 1'b0;
    step();
    chk_ct("os_resume", 2, 1'b0);

    // prescale 3 with en low for 2 cycles mid-period
    bus.mode     = 2'b00;
    bus.prescale = 4'd3;
    bus.load     = 1'b1;
    bus.load_val = 8'd0;
    step();
    chk_ct("pre_load", 0, 1'b0);
    bus.load = 1'b0;
    step();
    chk_ct("pre_e1", 0, 1'b0);
    step();
    chk_ct("pre_e2", 0, 1'b0);
    bus.en = 1'b0;
    step();
    chk_ct("pre_off1", 0, 1'b0);
    step();
    chk_ct("pre_off2", 0, 1'b0);
    bus.en = 1'b1;
    step();
    chk_ct("pre_e3", 0, 1'b0);
    step();
    chk_ct("pre_e4", 1, 1'b0);
    exp_c = '{1, 1, 1, 2};
    foreach (exp_c[i]) begin
      step();
      chk_ct("pre_period2", exp_c[i], 1'b0);
    end

    // rst beats load; load alone clamps 200 -> 9 without tc
    bus.prescale = 4'd0;
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'd200;
    step();
    chk_ct("rst_vs_load", 0, 1'b0);
    rst = 1'b0;
    step();
    chk_ct("load_clamp", 9, 1'b0);
    bus.load = 1'b0;

    // HOLD keeps count, then WRAP down from 9
    bus.mode = 2'b11;
    step();
    chk_ct("hold", 9, 1'b0);
    bus.mode = 2'b00;
    bus.dir  = 1'b0;
    step();
    chk_ct("wrap_down", 8, 1'b0);

    // down wrap 0 -> 9 is not a terminal arrival
    bus.load     = 1'b1;
    bus.load_val = 8'd0;
    step();
    chk_ct("load_term", 0, 1'b0);
    bus.load = 1'b0;
    step();
    chk_ct("down_wrap", 9, 1'b0);
    bus.dir = 1'b1;
    step();
    chk_ct("dir_flip", 0, 1'b0);

`ifdef COUNTER_CAPTURE_EN
    chk("cap reset", 32'(bus.cap_val), 32'd0);
    bus.load     = 1'b1;
    bus.load_val = 8'd6;
    step();
    bus.load = 1'b0;
    step();
    chk_ct("cap_pre", 7, 1'b0);
    bus.capture = 1'b1;
    step();
    bus.capture = 1'b0;
    chk_ct("cap_cnt", 8, 1'b0);
    chk("cap_val", 32'(bus.cap_val), 32'd7);
    step();
    chk_ct("cap_after", 9, 1'b1);
    chk("cap_hold", 32'(bus.cap_val), 32'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
